// File: rtl/esp32_spi_cmd_decoder.sv
// Byte-level command decoder between the ESP32 SPI slave and an 8-bit
// register bus: CS-framed write bursts and auto-incrementing read bursts.
module esp32_spi_cmd_decoder #(
  parameter logic [7:0] DEVICE_ID  = 8'hF1,
  parameter logic [7:0] CMD_WRITE  = 8'h01,
  parameter logic [7:0] CMD_READ   = 8'h02,
  parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       spi_busy,
  output logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       frame_active,
  output logic [7:0] cmd_err_cnt
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RDTURN, RDATA, DISCARD
  } state_t;

  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic       is_rd_q, is_rd_d;
  logic       rd_pend_q, rd_pend_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_load_q, tx_load_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic       frame_active_q, frame_active_d;
  logic [7:0] cmd_err_cnt_q, cmd_err_cnt_d;
  logic       rise, fall;

  assign rise = spi_busy & ~busy_q;
  assign fall = ~spi_busy & busy_q;

  always_comb begin
    state_d        = state_q;
    busy_d         = spi_busy;
    is_rd_d        = is_rd_q;
    rd_pend_d      = reg_rd_q;
    hold_d         = hold_q;
    tx_data_d      = tx_data_q;
    tx_load_d      = 1'b0;
    reg_addr_d     = reg_addr_q;
    reg_wdata_d    = reg_wdata_q;
    reg_wr_d       = 1'b0;
    reg_rd_d       = 1'b0;
    frame_active_d = frame_active_q;
    cmd_err_cnt_d  = cmd_err_cnt_q;

    // write bursts advance the address the cycle after each strobe
    if (reg_wr_q)
      reg_addr_d = reg_addr_q + 8'd1;

    if (rd_pend_q && !fall &&
        (state_q == RDTURN || state_q == RDATA))
      hold_d = reg_rdata;

    if (fall) begin
      state_d        = IDLE;
      tx_data_d      = DUMMY_BYTE;
      tx_load_d      = 1'b1;
      frame_active_d = 1'b0;
      rd_pend_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d        = CMD;
            tx_data_d      = DUMMY_BYTE;
            tx_load_d      = 1'b1;
            frame_active_d = 1'b1;
          end
        end
        CMD: begin
          if (rx_valid) begin
            tx_load_d = 1'b1;
            tx_data_d = DUMMY_BYTE;
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              state_d   = ADDR;
              tx_data_d = DEVICE_ID;
              is_rd_d   = (rx_data == CMD_READ);
            end else begin
              state_d = DISCARD;
              if (rx_data != 8'h00 && cmd_err_cnt_q != 8'hFF)
                cmd_err_cnt_d = cmd_err_cnt_q + 8'd1;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            reg_addr_d = rx_data;
            tx_data_d  = DUMMY_BYTE;
            tx_load_d  = 1'b1;
            if (is_rd_q) begin
              reg_rd_d = 1'b1;
              state_d  = RDTURN;
            end else begin
              state_d  = WDATA;
            end
          end
        end
        WDATA: begin
          if (rx_valid) begin
            reg_wdata_d = rx_data;
            reg_wr_d    = 1'b1;
            tx_data_d   = DUMMY_BYTE;
            tx_load_d   = 1'b1;
          end
        end
        RDTURN, RDATA: begin
          // MOSI byte is ignored; it just clocks out the held read data
          if (rx_valid) begin
            tx_data_d  = hold_q;
            tx_load_d  = 1'b1;
            reg_addr_d = reg_addr_q + 8'd1;
            reg_rd_d   = 1'b1;
            state_d    = RDATA;
          end
        end
        DISCARD: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      is_rd_q        <= 1'b0;
      rd_pend_q      <= 1'b0;
      hold_q         <= 8'h00;
      tx_data_q      <= DUMMY_BYTE;
      tx_load_q      <= 1'b0;
      reg_addr_q     <= 8'h00;
      reg_wdata_q    <= 8'h00;
      reg_wr_q       <= 1'b0;
      reg_rd_q       <= 1'b0;
      frame_active_q <= 1'b0;
      cmd_err_cnt_q  <= 8'h00;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      is_rd_q        <= is_rd_d;
      rd_pend_q      <= rd_pend_d;
      hold_q         <= hold_d;
      tx_data_q      <= tx_data_d;
      tx_load_q      <= tx_load_d;
      reg_addr_q     <= reg_addr_d;
      reg_wdata_q    <= reg_wdata_d;
      reg_wr_q       <= reg_wr_d;
      reg_rd_q       <= reg_rd_d;
      frame_active_q <= frame_active_d;
      cmd_err_cnt_q  <= cmd_err_cnt_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_load      = tx_load_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wdata    = reg_wdata_q;
  assign reg_wr       = reg_wr_q;
  assign reg_rd       = reg_rd_q;
  assign frame_active = frame_active_q;
  assign cmd_err_cnt  = cmd_err_cnt_q;

endmodule
